// File: rtl/atan2_cordic.sv
// Sequential vectoring-mode CORDIC: one micro-rotation per clock, producing
// atan2(y,x) in 2048 units/turn and a gain-compensated magnitude.
module atan2_cordic #(
    parameter int ITERS = 12
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic signed [15:0] x_in,
    input  logic signed [15:0] y_in,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [15:0]        angle,
    output logic [15:0]        magnitude
);

    typedef enum logic [1:0] {IDLE, ITER, POST, DONE} state_t;

    localparam logic [3:0] LAST_ITER = 4'(ITERS - 1);

    state_t             r_state;
    state_t             w_next;
    logic signed [18:0] r_x;
    logic signed [18:0] r_y;
    logic [14:0]        r_z;
    logic [3:0]         r_cnt;
    logic               r_zero;
    logic [10:0]        r_angle;
    logic [15:0]        r_mag;

    logic signed [18:0] w_x_ext;
    logic signed [18:0] w_y_ext;
    logic signed [18:0] w_x_sh;
    logic signed [18:0] w_y_sh;
    logic [14:0]        w_atan;
    logic [14:0]        w_z_rnd;
    logic signed [28:0] w_prod;
    logic signed [28:0] w_scaled;
    logic [15:0]        w_mag_sat;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    // NOTE: w_next takes a default first so no path through the case infers a latch.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (in_valid) w_next = ITER;
            ITER:    if (r_cnt == LAST_ITER) w_next = POST;
            POST:    w_next = DONE;
            DONE:    if (out_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign angle     = {5'd0, r_angle};
    assign magnitude = r_mag;

    // Elementary angles atan(2^-i) in 1/16 of an output LSB (32768 per turn).
    always_comb begin
        w_atan = 15'd0;
        case (r_cnt)
            4'd0:    w_atan = 15'd4096;
            4'd1:    w_atan = 15'd2418;
            4'd2:    w_atan = 15'd1278;
            4'd3:    w_atan = 15'd649;
            4'd4:    w_atan = 15'd326;
            4'd5:    w_atan = 15'd163;
            4'd6:    w_atan = 15'd81;
            4'd7:    w_atan = 15'd41;
            4'd8:    w_atan = 15'd20;
            4'd9:    w_atan = 15'd10;
            4'd10:   w_atan = 15'd5;
            4'd11:   w_atan = 15'd3;
            default: w_atan = 15'd0;
        endcase
    end

    assign w_x_ext = 19'(x_in);
    assign w_y_ext = 19'(y_in);
    assign w_x_sh  = r_x >>> r_cnt;
    assign w_y_sh  = r_y >>> r_cnt;

    // Z wraps modulo 2^15, so rounding past a full turn lands back on angle 0.
    assign w_z_rnd  = r_z + 15'd8;
    assign w_prod   = 29'(r_x) * 29'sd311;
    assign w_scaled = w_prod >>> 9;

    always_comb begin
        w_mag_sat = {1'b0, w_scaled[14:0]};
        if (w_scaled[28])            w_mag_sat = 16'd0;
        else if (|w_scaled[27:15])   w_mag_sat = 16'h7FFF;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_x     <= '0;
            r_y     <= '0;
            r_z     <= '0;
            r_cnt   <= '0;
            r_zero  <= 1'b0;
            r_angle <= '0;
            r_mag   <= '0;
        end else begin
            case (r_state)
                IDLE: if (in_valid) begin
                    r_cnt  <= '0;
                    r_zero <= (x_in == 16'sd0) && (y_in == 16'sd0);
                    if (x_in < 16'sd0) begin
                        r_x <= -w_x_ext;
                        r_y <= -w_y_ext;
                        r_z <= 15'd16384;
                    end else begin
                        r_x <= w_x_ext;
                        r_y <= w_y_ext;
                        r_z <= 15'd0;
                    end
                end
                ITER: begin
                    r_cnt <= r_cnt + 4'd1;
                    if (r_y >= 19'sd0) begin
                        r_x <= r_x + w_y_sh;
                        r_y <= r_y - w_x_sh;
                        r_z <= r_z + w_atan;
                    end else begin
                        r_x <= r_x - w_y_sh;
                        r_y <= r_y + w_x_sh;
                        r_z <= r_z - w_atan;
                    end
                end
                POST: begin
                    if (r_zero) begin
                        r_angle <= '0;
                        r_mag   <= '0;
                    end else begin
                        r_angle <= 11'(w_z_rnd >> 4);
                        r_mag   <= w_mag_sat;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_atan2_cordic.sv
// Self-checking bench for atan2_cordic: directed corner vectors, handshake and
// reset behaviour, and random vectors scored against a real-arithmetic model.
module tb_atan2_cordic;

    localparam int  ITERS = 12;
    localparam real PI    = 3.14159265358979323846;

    logic               clk = 1'b0;
    logic               reset;
    logic               in_valid;
    logic               in_ready;
    logic signed [15:0] x_in;
    logic signed [15:0] y_in;
    logic               out_valid;
    logic               out_ready;
    logic [15:0]        angle;
    logic [15:0]        magnitude;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        int x;
        int y;
        int ang;
        int atol;
        int mag;
        int mtol;
    } vec_t;

    atan2_cordic #(.ITERS(ITERS)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x_in      (x_in),
        .y_in      (y_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .angle     (angle),
        .magnitude (magnitude)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // modulus > 0 makes the tolerance circular (angle wrap-around).
    task automatic check(input string tag, input int act, input int exp, input int tol, input int modulus);
        int d;
        n_checks++;
        d = act - exp;
        if (modulus > 0) begin
            d = ((d % modulus) + modulus) % modulus;
            if (d > modulus / 2) d = d - modulus;
        end
        if (d < 0) d = -d;
        if (d <= tol) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (tol %0d)", tag, act, exp, tol);
    endtask

    function automatic int ref_angle(input int x, input int y);
        real a;
        int  r;
        if (x == 0 && y == 0) return 0;
        a = $atan2(real'(y), real'(x)) * 2048.0 / (2.0 * PI);
        r = $rtoi($floor(a + 0.5));
        return ((r % 2048) + 2048) % 2048;
    endfunction

    function automatic int ref_mag(input int x, input int y);
        real m;
        m = $sqrt(real'(x) * real'(x) + real'(y) * real'(y));
        if (m > 32767.0) m = 32767.0;
        return $rtoi($floor(m + 0.5));
    endfunction

    // Present one operand pair from IDLE and wait (bounded) for the result.
    task automatic run_op(input int x, input int y, output int a, output int m);
        int lat;
        check("in_ready_before_op", int'(in_ready), 1, 0, 0);
        x_in     = 16'(x);
        y_in     = 16'(y);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        check("latency", lat, ITERS + 1, 0, 0);
        a = int'(angle);
        m = int'(magnitude);
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("consume_in_ready", int'(in_ready), 1, 0, 0);
        check("consume_out_valid", int'(out_valid), 0, 0, 0);
    endtask

    initial begin
        vec_t dir[8];
        int a, m, a0, m0, bad, rx, ry;

        dir[0] = '{256, 0, 0, 1, 256, 3};
        dir[1] = '{0, 256, 512, 1, 256, 3};
        dir[2] = '{-256, 0, 1024, 1, 256, 3};
        dir[3] = '{0, -256, 1536, 1, 256, 3};
        dir[4] = '{256, -256, 1792, 1, 362, 4};
        dir[5] = '{181, 181, 256, 1, 256, 3};
        dir[6] = '{0, 0, 0, 0, 0, 0};
        dir[7] = '{-32768, -32768, 1280, 1, 32767, 0};

        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        x_in      = '0;
        y_in      = '0;
        #1;
        check("rst_in_ready", int'(in_ready), 1, 0, 0);
        check("rst_out_valid", int'(out_valid), 0, 0, 0);
        check("rst_angle", int'(angle), 0, 0, 0);
        check("rst_magnitude", int'(magnitude), 0, 0, 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // out_ready while idle must not disturb anything.
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("idle_out_ready_in_ready", int'(in_ready), 1, 0, 0);
        check("idle_out_ready_out_valid", int'(out_valid), 0, 0, 0);

        foreach (dir[i]) begin
            run_op(dir[i].x, dir[i].y, a, m);
            check($sformatf("dir%0d_angle", i), a, dir[i].ang, dir[i].atol, 2048);
            check($sformatf("dir%0d_mag", i), m, dir[i].mag, dir[i].mtol, 0);
            check($sformatf("dir%0d_angle_hi", i), int'(angle[15:11]), 0, 0, 0);
            consume();
        end

        // Back-pressure: result held for 20 cycles, input pulses ignored.
        run_op(1000, -500, a0, m0);
        check("stall_angle", a0, ref_angle(1000, -500), 1, 2048);
        check("stall_mag", m0, ref_mag(1000, -500), ref_mag(1000, -500) / 100 + 2, 0);
        bad = 0;
        for (int c = 0; c < 20; c++) begin
            in_valid = c[0];
            x_in     = 16'($urandom);
            y_in     = 16'($urandom);
            @(posedge clk); #1;
            if (!out_valid || in_ready || int'(angle) != a0 || int'(magnitude) != m0) bad++;
        end
        check("stall_stable_cycles_bad", bad, 0, 0, 0);
        // Consume with in_valid still high: the pair must not be accepted.
        in_valid  = 1'b1;
        x_in      = 16'sd256;
        y_in      = 16'sd0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check("stall_release_in_ready", int'(in_ready), 1, 0, 0);
        check("stall_release_out_valid", int'(out_valid), 0, 0, 0);
        @(posedge clk); #1;
        check("no_accept_on_consume", int'(in_ready), 1, 0, 0);

        // Reset at iteration 5 aborts the computation.
        x_in     = 16'sd300;
        y_in     = 16'sd400;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1 reset = 1'b1;
        #1;
        check("midrst_in_ready", int'(in_ready), 1, 0, 0);
        check("midrst_out_valid", int'(out_valid), 0, 0, 0);
        check("midrst_angle", int'(angle), 0, 0, 0);
        check("midrst_magnitude", int'(magnitude), 0, 0, 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        check("midrst_after_out_valid", int'(out_valid), 0, 0, 0);
        run_op(256, 0, a, m);
        check("midrst_new_angle", a, 0, 1, 2048);
        check("midrst_new_mag", m, 256, 3, 0);
        consume();

        // Reset while a result waits in DONE discards it.
        run_op(300, 400, a, m);
        check("done_rst_pre_valid", int'(out_valid), 1, 0, 0);
        #1 reset = 1'b1;
        #1;
        check("done_rst_out_valid", int'(out_valid), 0, 0, 0);
        check("done_rst_in_ready", int'(in_ready), 1, 0, 0);
        @(posedge clk); #1 reset = 1'b0;

        // Random vectors with magnitude large enough for +-1 LSB angle accuracy.
        for (int n = 0; n < 30; n++) begin
            do begin
                rx = int'($urandom_range(0, 65535)) - 32768;
                ry = int'($urandom_range(0, 65535)) - 32768;
            end while (ref_mag(rx, ry) < 2048);
            run_op(rx, ry, a, m);
            check($sformatf("rnd%0d_angle(%0d,%0d)", n, rx, ry), a, ref_angle(rx, ry), 1, 2048);
            check($sformatf("rnd%0d_mag(%0d,%0d)", n, rx, ry), m, ref_mag(rx, ry),
                  ref_mag(rx, ry) / 100 + 2, 0);
            consume();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
